// File: rtl/cubo_caida.sv
// Falling-cube generator and catch detector: spawns a cube at an LFSR column, drops it once per
// frame and scores catches/misses. Define CUBO_ACELERACION_EN to speed up every 8 catches.
module cubo_caida #(
    parameter int         MAX_X             = 640,
    parameter int         MAX_Y             = 480,
    parameter int         TAMANIO_CUBO      = 16,
    parameter int         ANCHO_CANASTA     = 90,
    parameter logic [2:0] VELOCIDAD_INICIAL = 3'd2,
    parameter int         ESPERA_FRAMES     = 30,
    parameter logic [9:0] SEMILLA           = 10'h2A5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [9:0] pos_x_canasta,
    input  logic [8:0] pos_y_canasta,
    output logic [9:0] pos_x_cubo,
    output logic [9:0] pos_y_cubo,
    output logic       pintar_cubo,
    output logic       atrapado,
    output logic       perdido,
    output logic [7:0] puntaje,
    output logic [1:0] vidas,
    output logic       juego_terminado
);

    // state      | meaning
    // E_ESPERA   | counting frames until the next spawn
    // E_CAYENDO  | cube falling, one step per frame tick
    // E_ATRAPADO | one-cycle catch pulse, score update
    // E_PERDIDO  | one-cycle miss pulse, lose a life
    // E_FIN      | game over, left only through reset
    typedef enum logic [2:0] {
        E_ESPERA,
        E_CAYENDO,
        E_ATRAPADO,
        E_PERDIDO,
        E_FIN
    } estado_t;

    localparam logic [7:0]  ESPERA_CNT = 8'(ESPERA_FRAMES);
    localparam logic [9:0]  LIM_X      = 10'(MAX_X - TAMANIO_CUBO);
    localparam logic [10:0] LIM_Y      = 11'(MAX_Y);
    localparam logic [10:0] LADO       = 11'(TAMANIO_CUBO);
    localparam logic [10:0] ANCHO      = 11'(ANCHO_CANASTA);

    estado_t     estado, estado_sig;
    logic [9:0]  lfsr, lfsr_sig;
    logic [7:0]  cuenta, cuenta_sig;
    logic [9:0]  pos_x_sig, pos_y_sig;
    logic [7:0]  puntaje_sig, puntaje_inc;
    logic [1:0]  vidas_sig;
    logic [2:0]  velocidad, velocidad_sig;
    logic        tick;
    logic [9:0]  columna;
    logic [10:0] y_sig, abajo_act, abajo_sig, canasta_y, canasta_der, cubo_der;
    logic        cruza, solapa, dentro_x, dentro_y;

    always_ff @(posedge clk) begin
        if (!reset) begin
            estado     <= E_ESPERA;
            cuenta     <= ESPERA_CNT;
            lfsr       <= SEMILLA;
            pos_x_cubo <= 10'd0;
            pos_y_cubo <= 10'd0;
            puntaje    <= 8'd0;
            vidas      <= 2'd3;
            velocidad  <= VELOCIDAD_INICIAL;
        end else begin
            estado     <= estado_sig;
            cuenta     <= cuenta_sig;
            lfsr       <= lfsr_sig;
            pos_x_cubo <= pos_x_sig;
            pos_y_cubo <= pos_y_sig;
            puntaje    <= puntaje_sig;
            vidas      <= vidas_sig;
            velocidad  <= velocidad_sig;
        end
    end

    always_comb begin
        tick        = (pixel_y == 10'd481) && (pixel_x == 10'd0);
        lfsr_sig    = tick ? {lfsr[8:0], lfsr[9] ^ lfsr[6]} : lfsr;
        // Columns past the right edge fold back by 512 so the cube always fits on screen.
        columna     = (lfsr > LIM_X) ? (lfsr - 10'd512) : lfsr;
        y_sig       = {1'b0, pos_y_cubo} + {8'd0, velocidad};
        abajo_act   = {1'b0, pos_y_cubo} + LADO;
        abajo_sig   = y_sig + LADO;
        canasta_y   = {2'b00, pos_y_canasta};
        cubo_der    = {1'b0, pos_x_cubo} + LADO;
        canasta_der = {1'b0, pos_x_canasta} + ANCHO;
        // Only the frame whose step crosses the basket top can score a catch.
        cruza       = (abajo_act < canasta_y) && (abajo_sig >= canasta_y);
        solapa      = (cubo_der > {1'b0, pos_x_canasta}) && ({1'b0, pos_x_cubo} < canasta_der);
        puntaje_inc = (puntaje == 8'hFF) ? 8'hFF : (puntaje + 8'd1);

        estado_sig    = estado;
        cuenta_sig    = cuenta;
        pos_x_sig     = pos_x_cubo;
        pos_y_sig     = pos_y_cubo;
        puntaje_sig   = puntaje;
        vidas_sig     = vidas;
        velocidad_sig = velocidad;

        case (estado)
            E_ESPERA: begin
                if (tick) begin
                    if (cuenta == 8'd1) begin
                        pos_x_sig  = columna;
                        pos_y_sig  = 10'd0;
                        estado_sig = E_CAYENDO;
                    end else begin
                        cuenta_sig = cuenta - 8'd1;
                    end
                end
            end
            E_CAYENDO: begin
                if (tick) begin
                    if (cruza && solapa) begin
                        pos_y_sig  = y_sig[9:0];
                        estado_sig = E_ATRAPADO;
                    end else if (abajo_sig >= LIM_Y) begin
                        estado_sig = E_PERDIDO;
                    end else begin
                        pos_y_sig = y_sig[9:0];
                    end
                end
            end
            E_ATRAPADO: begin
                puntaje_sig = puntaje_inc;
                cuenta_sig  = ESPERA_CNT;
                estado_sig  = E_ESPERA;
`ifdef CUBO_ACELERACION_EN
                if ((puntaje_inc[2:0] == 3'd0) && (velocidad != 3'd7))
                    velocidad_sig = velocidad + 3'd1;
`else
                velocidad_sig = VELOCIDAD_INICIAL;
`endif
            end
            E_PERDIDO: begin
                vidas_sig = vidas - 2'd1;
                if (vidas == 2'd1) begin
                    estado_sig = E_FIN;
                end else begin
                    cuenta_sig = ESPERA_CNT;
                    estado_sig = E_ESPERA;
                end
            end
            E_FIN: begin
                estado_sig = E_FIN;
            end
            default: begin
                estado_sig = E_ESPERA;
            end
        endcase
    end

    always_comb begin
        dentro_x    = ({1'b0, pixel_x} >= {1'b0, pos_x_cubo}) && ({1'b0, pixel_x} < cubo_der);
        dentro_y    = ({1'b0, pixel_y} >= {1'b0, pos_y_cubo}) && ({1'b0, pixel_y} < abajo_act);
        pintar_cubo = (estado == E_CAYENDO) && dentro_x && dentro_y;
    end

    assign atrapado        = (estado == E_ATRAPADO);
    assign perdido         = (estado == E_PERDIDO);
    assign juego_terminado = (estado == E_FIN);

endmodule

// File: tb/tb_cubo_caida.sv
// Scoreboard bench for cubo_caida: frame ticks are driven directly on pixel_x/pixel_y and
// expected catch/miss events are queued before the deciding tick.
module tb_cubo_caida;

    localparam logic [9:0] SEMILLA = 10'h2A5;
    localparam int         ESPERA  = 30;
    localparam int         VEL0    = 2;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] pixel_x, pixel_y, pos_x_canasta;
    logic [8:0] pos_y_canasta;
    logic [9:0] pos_x_cubo, pos_y_cubo;
    logic       pintar_cubo, atrapado, perdido, juego_terminado;
    logic [7:0] puntaje;
    logic [1:0] vidas;

    cubo_caida dut (
        .clk             (clk),
        .reset           (reset),
        .pixel_x         (pixel_x),
        .pixel_y         (pixel_y),
        .pos_x_canasta   (pos_x_canasta),
        .pos_y_canasta   (pos_y_canasta),
        .pos_x_cubo      (pos_x_cubo),
        .pos_y_cubo      (pos_y_cubo),
        .pintar_cubo     (pintar_cubo),
        .atrapado        (atrapado),
        .perdido         (perdido),
        .puntaje         (puntaje),
        .vidas           (vidas),
        .juego_terminado (juego_terminado)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit es_captura;
        int y;
    } evento_t;

    evento_t    sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [9:0] m_lfsr;
    int         exp_x, exp_y, exp_score, exp_vel, exp_lives;
    bit         ultimo_captura;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (atrapado || perdido) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, atrapado, perdido}, 32'd0);
            end else begin
                evento_t e;
                e = sb_q.pop_front();
                chk("pulse_atrapado", atrapado, e.es_captura);
                chk("pulse_perdido", perdido, !e.es_captura);
                chk("pulse_pos_y", pos_y_cubo, e.y);
            end
        end
    end

    task automatic modelo_reset();
        m_lfsr    = SEMILLA;
        exp_score = 0;
        exp_vel   = VEL0;
        exp_lives = 3;
        exp_x     = 0;
        exp_y     = 0;
    endtask

    task automatic tick_frame();
        @(negedge clk);
        pixel_x = 10'd0;
        pixel_y = 10'd481;
        @(negedge clk);
        pixel_x = 10'd7;
        pixel_y = 10'd490;
        m_lfsr  = {m_lfsr[8:0], m_lfsr[9] ^ m_lfsr[6]};
    endtask

    task automatic check_reset_vals();
        pixel_x = 10'd0;
        pixel_y = 10'd0;
        #1;
        chk("rst_vidas", vidas, 3);
        chk("rst_puntaje", puntaje, 0);
        chk("rst_pos_x", pos_x_cubo, 0);
        chk("rst_pos_y", pos_y_cubo, 0);
        chk("rst_pintar", pintar_cubo, 0);
        chk("rst_pulses", {atrapado, perdido, juego_terminado}, 0);
        chk("rst_velocidad", dut.velocidad, VEL0);
        pixel_x = 10'd7;
        pixel_y = 10'd490;
    endtask

    task automatic spawn();
        for (int i = 0; i < ESPERA - 1; i++) tick_frame();
        exp_x = (m_lfsr > 10'd624) ? int'(m_lfsr) - 512 : int'(m_lfsr);
        exp_y = 0;
        tick_frame();
        chk("spawn_x", pos_x_cubo, exp_x);
        chk("spawn_y", pos_y_cubo, 0);
        chk("spawn_x_range", pos_x_cubo <= 10'd624, 1);
    endtask

    task automatic fall(input logic [9:0] bx, input logic [8:0] by, input int max_frames,
                        output bit decidido);
        int  ysig;
        bit  ov;
        int  frames;
        pos_x_canasta = bx;
        pos_y_canasta = by;
        decidido = 0;
        frames   = 0;
        ov = (exp_x + 16 > int'(bx)) && (exp_x < int'(bx) + 90);
        while (!decidido && frames < max_frames) begin
            ysig = exp_y + exp_vel;
            if ((exp_y + 16 < int'(by)) && (ysig + 16 >= int'(by)) && ov) begin
                sb_q.push_back('{1'b1, ysig});
                exp_y = ysig;
                ultimo_captura = 1;
                decidido = 1;
            end else if (ysig + 16 >= 480) begin
                sb_q.push_back('{1'b0, exp_y});
                ultimo_captura = 0;
                decidido = 1;
            end else begin
                exp_y = ysig;
            end
            tick_frame();
            frames++;
        end
    endtask

    task automatic resolve();
        @(negedge clk);
        chk("pulse_seen", sb_q.size(), 0);
        if (ultimo_captura) begin
            exp_score = (exp_score == 255) ? 255 : exp_score + 1;
`ifdef CUBO_ACELERACION_EN
            if ((exp_score % 8 == 0) && exp_vel < 7) exp_vel++;
`endif
        end else begin
            exp_lives--;
        end
        chk("puntaje", puntaje, exp_score);
        chk("vidas", vidas, exp_lives);
        chk("pulse_low", {atrapado, perdido}, 0);
    endtask

    task automatic cubo(input int modo);
        logic [9:0] bx;
        bit         dec;
        spawn();
        case (modo)
            0: bx = 10'(exp_x);
            1: bx = 10'(exp_x + 16);
            2: bx = 10'(exp_x + 15);
            3: bx = (exp_x >= 89) ? 10'(exp_x - 89) : 10'(exp_x);
            default: bx = (exp_x >= 320) ? 10'd0 : 10'd600;
        endcase
        fall(bx, 9'd447, 400, dec);
        if (!dec) chk("fall_timeout", 1, 0);
        resolve();
    endtask

    task automatic scan_box(input int expected);
        int cnt = 0;
        for (int yy = exp_y - 1; yy <= exp_y + 16; yy++) begin
            for (int xx = exp_x - 1; xx <= exp_x + 16; xx++) begin
                if (yy >= 0 && xx >= 0 && yy < 1024 && xx < 1024) begin
                    @(negedge clk);
                    pixel_x = xx[9:0];
                    pixel_y = yy[9:0];
                    #1;
                    if (pintar_cubo) cnt++;
                end
            end
        end
        @(negedge clk);
        pixel_x = 10'd7;
        pixel_y = 10'd490;
        chk("pintar_count", cnt, expected);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit dec;
        reset         = 1'b0;
        pixel_x       = 10'd7;
        pixel_y       = 10'd490;
        pos_x_canasta = 10'd0;
        pos_y_canasta = 9'd447;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        modelo_reset();

        // First cube: paint area while falling, then a centred catch.
        spawn();
        scan_box(256);
        fall(10'(exp_x), 9'd447, 400, dec);
        if (!dec) chk("fall_timeout", 1, 0);
        resolve();
        scan_box(0);

        cubo(1);
        cubo(2);
        cubo(3);
        repeat (5) cubo(0);
        chk("puntaje_8", puntaje, 8);
        chk("velocidad", dut.velocidad, exp_vel);

        // Reset in the middle of a fall.
        spawn();
        fall((exp_x >= 320) ? 10'd0 : 10'd600, 9'd447, 50, dec);
        chk("midfall_y", pos_y_cubo, exp_y);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        modelo_reset();

        repeat (3) cubo(4);
        chk("fin_flag", juego_terminado, 1);
        chk("fin_vidas", vidas, 0);

        for (int i = 0; i < 100; i++) begin
            tick_frame();
            @(negedge clk);
            pixel_x = 10'(exp_x);
            pixel_y = 10'(exp_y);
            #1;
            chk("fin_pintar", pintar_cubo, 0);
        end
        chk("fin_flag_hold", juego_terminado, 1);
        chk("fin_vidas_hold", vidas, 0);
        chk("fin_puntaje", puntaje, exp_score);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
